instr_fetch: RTL and testbench



---
 rtl/riscv_pkg.sv | 32 +++
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch_pc_next.sv | 43 ++++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the tiny RISC-V core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: XLEN, the canonical NOP encoding, the fetch-stage state enum,
// the IF/ID pipeline register layout and a word-align helper.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  // Force an address onto a 32-bit instruction boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of fetch-stage control, instruction-memory and IF/ID signals.
// Latency: n/a (wiring only).
// Backpressure: stall_i from hazard logic holds the stage; redirect_valid_i overrides it.
//
// Modports: master = the fetch stage, slave = surrounding core / memory.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            stall_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_instr_i;
  logic            if_id_valid_o;
  logic [XLEN-1:0] if_id_instr_o;
  logic [XLEN-1:0] if_id_pc_o;
  logic [XLEN-1:0] if_id_pc_plus4_o;
  logic            fetch_fault_o;

  modport master (
    input  stall_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o,
           if_id_pc_plus4_o, fetch_fault_o
  );

  modport slave (
    output stall_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o,
           if_id_pc_plus4_o, fetch_fault_o
  );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC select (redirect / hold / +4) plus fetch range and redirect alignment checks.
// Latency: purely combinational.
// Backpressure: stall_i or a non-RUN state selects hold; redirect always wins.
//
// Ports: pc_i/state_i current PC and fetch state; stall_i, redirect_valid_i,
// redirect_pc_i control; next_pc_o, pc_plus4_o, in_range_o, misaligned_o results.
module pc_next
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic [XLEN-1:0] pc_i,
  input  fetch_state_t    state_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            in_range_o,
  output logic            misaligned_o
);

  localparam logic [XLEN-1:0] IMEM_WORDS_W = XLEN'(IMEM_WORDS);

  // Wraps modulo 2^32 naturally.
  assign pc_plus4_o = pc_i + 32'd4;

  // Compare the full word index so far-out-of-range PCs cannot alias
  // back into the memory through truncation.
  assign in_range_o = ({2'b00, pc_i[XLEN-1:2]} < IMEM_WORDS_W);

  assign misaligned_o = (redirect_pc_i[1:0] != 2'b00);

  always_comb begin
    next_pc_o = pc_i;
    if (redirect_valid_i) begin
      next_pc_o = align_word(redirect_pc_i);
    end else if (state_i == RUN && !stall_i && in_range_o) begin
      next_pc_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, BOOT/RUN/HALT control and IF/ID pipeline register.
// Latency: instruction at PC in cycle N appears on IF/ID in cycle N+1; one per cycle.
// Backpressure: stall holds PC/IF/ID/state; redirect overrides stall and flushes IF/ID.
//
// Ports: clk, rstn (synchronous, active-low); bus (instr_fetch_if.master) carrying
// stall/redirect inputs, imem address/data and IF/ID + fetch_fault outputs.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rstn,
  instr_fetch_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  if_id_t          if_id;
  logic            fault;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            in_range;
  logic            misaligned;

  pc_next #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_next (
    .pc_i             (pc),
    .state_i          (state),
    .stall_i          (bus.stall_i),
    .redirect_valid_i (bus.redirect_valid_i),
    .redirect_pc_i    (bus.redirect_pc_i),
    .next_pc_o        (next_pc),
    .pc_plus4_o       (pc_plus4),
    .in_range_o       (in_range),
    .misaligned_o     (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      if_id.valid    <= 1'b0;
      if_id.instr    <= NOP_INSTR;
      if_id.pc       <= '0;
      if_id.pc_plus4 <= '0;
      fault          <= 1'b0;
    end else begin
      // Fault is a single-cycle pulse unless re-raised below.
      fault <= 1'b0;
      if (bus.redirect_valid_i) begin
        // Redirect is honoured from any state, including HALT and BOOT.
        pc          <= next_pc;
        if_id.valid <= 1'b0;
        if_id.instr <= NOP_INSTR;
        fault       <= misaligned;
        state       <= RUN;
      end else begin
        unique case (state)
          BOOT: begin
            // PC already holds RESET_PC; spend one cycle, ignoring stall.
            state <= RUN;
          end
          RUN: begin
            if (!bus.stall_i) begin
              if (in_range) begin
                if_id.valid    <= 1'b1;
                if_id.instr    <= bus.imem_instr_i;
                if_id.pc       <= pc;
                if_id.pc_plus4 <= pc_plus4;
                pc             <= next_pc;
              end else begin
                if_id.valid <= 1'b0;
                if_id.instr <= NOP_INSTR;
                fault       <= 1'b1;
                state       <= HALT;
              end
            end
          end
          HALT: begin
            // Frozen until a redirect arrives.
            if_id.valid <= 1'b0;
          end
          default: begin
            state <= HALT;
          end
        endcase
      end
    end
  end

  assign bus.imem_addr_o      = pc;
  assign bus.if_id_valid_o    = if_id.valid;
  assign bus.if_id_instr_o    = if_id.instr;
  assign bus.if_id_pc_o       = if_id.pc;
  assign bus.if_id_pc_plus4_o = if_id.pc_plus4;
  assign bus.fetch_fault_o    = fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural model tracks expected
// outputs every cycle, and directed steps add hand-computed literal checks.
module tb_instr_fetch;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  instr_fetch_if bus_if ();

  instr_fetch dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: addi x1, x0, idx
  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return {idx[11:0], 20'h0_0093};
  endfunction

  assign bus_if.imem_instr_i = ((bus_if.imem_addr_o >> 2) < 32'd64)
                               ? mem_word(bus_if.imem_addr_o >> 2) : 32'hDEAD_BEEF;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid, m_fault;
  bit          m_booting, m_halted, model_live;

  always @(posedge clk) begin
    if (!rstn) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13;
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_fault = 1'b0;
      m_booting = 1'b1; m_halted = 1'b0; model_live = 1'b1;
    end else if (model_live) begin
      m_fault = 1'b0;
      if (bus_if.redirect_valid_i) begin
        m_pc      = bus_if.redirect_pc_i & ~32'h3;
        m_valid   = 1'b0;
        m_instr   = 32'h13;
        m_fault   = (bus_if.redirect_pc_i % 4) != 0;
        m_booting = 1'b0;
        m_halted  = 1'b0;
      end else if (m_booting) begin
        m_booting = 1'b0;
      end else if (m_halted || bus_if.stall_i) begin
        // nothing moves
      end else if (m_pc / 4 < 64) begin
        m_valid = 1'b1;
        m_instr = mem_word(m_pc / 4);
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 4;
        m_pc    = m_pc + 4;
      end else begin
        m_valid  = 1'b0;
        m_instr  = 32'h13;
        m_fault  = 1'b1;
        m_halted = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      cmp("m_imem_addr", bus_if.imem_addr_o, m_pc);
      cmp("m_valid", {31'b0, bus_if.if_id_valid_o}, {31'b0, m_valid});
      cmp("m_instr", bus_if.if_id_instr_o, m_instr);
      cmp("m_fault", {31'b0, bus_if.fetch_fault_o}, {31'b0, m_fault});
      if (m_valid) begin
        cmp("m_pc", bus_if.if_id_pc_o, m_ipc);
        cmp("m_pc4", bus_if.if_id_pc_plus4_o, m_ipc4);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus_if.redirect_valid_i = 1'b1;
    bus_if.redirect_pc_i    = tgt;
    cyc(1);
    bus_if.redirect_valid_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_live = 1'b0;
    rstn = 1'b0;
    bus_if.stall_i = 1'b0;
    bus_if.redirect_valid_i = 1'b0;
    bus_if.redirect_pc_i = 32'h0;
    cyc(3);

    // Reset values
    cmp("rst_addr", bus_if.imem_addr_o, 32'h0);
    cmp("rst_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    cmp("rst_instr", bus_if.if_id_instr_o, 32'h13);
    cmp("rst_pc", bus_if.if_id_pc_o, 32'h0);
    cmp("rst_pc4", bus_if.if_id_pc_plus4_o, 32'h0);
    cmp("rst_fault", {31'b0, bus_if.fetch_fault_o}, 32'h0);

    // Release: cycle 0 is this cycle
    rstn = 1'b1;
    cmp("c0_addr", bus_if.imem_addr_o, 32'h0);
    cyc(1);
    cmp("c1_addr", bus_if.imem_addr_o, 32'h0);
    cmp("c1_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    cyc(1);
    cmp("c2_addr", bus_if.imem_addr_o, 32'h4);
    cmp("c2_valid", {31'b0, bus_if.if_id_valid_o}, 32'h1);
    cmp("c2_pc", bus_if.if_id_pc_o, 32'h0);
    cmp("c2_instr", bus_if.if_id_instr_o, 32'h0000_0093);
    cmp("c2_pc4", bus_if.if_id_pc_plus4_o, 32'h4);
    cyc(1);
    cmp("c3_addr", bus_if.imem_addr_o, 32'h8);

    // Stall three cycles at PC = 8
    bus_if.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      cmp("stall_addr", bus_if.imem_addr_o, 32'h8);
      cmp("stall_pc", bus_if.if_id_pc_o, 32'h4);
    end
    bus_if.stall_i = 1'b0;
    cyc(1);
    cmp("unstall_pc", bus_if.if_id_pc_o, 32'h8);
    cmp("unstall_addr", bus_if.imem_addr_o, 32'hC);

    // Redirect to 0x20 from PC = 12
    redirect(32'h20);
    cmp("rd_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    cmp("rd_instr", bus_if.if_id_instr_o, 32'h13);
    cmp("rd_addr", bus_if.imem_addr_o, 32'h20);
    cyc(1);
    cmp("rd2_pc", bus_if.if_id_pc_o, 32'h20);
    cmp("rd2_instr", bus_if.if_id_instr_o, 32'h0080_0093);
    cmp("rd2_valid", {31'b0, bus_if.if_id_valid_o}, 32'h1);

    // Redirect and stall together
    bus_if.stall_i = 1'b1;
    redirect(32'h10);
    cmp("rdst_addr", bus_if.imem_addr_o, 32'h10);
    bus_if.stall_i = 1'b0;
    cyc(1);
    cmp("rdst_pc", bus_if.if_id_pc_o, 32'h10);

    // Misaligned redirect
    redirect(32'h22);
    cmp("mis_addr", bus_if.imem_addr_o, 32'h20);
    cmp("mis_fault", {31'b0, bus_if.fetch_fault_o}, 32'h1);
    cyc(1);
    cmp("mis_fault_end", {31'b0, bus_if.fetch_fault_o}, 32'h0);

    // Far out of range: word index 0x100 must not alias to 0
    redirect(32'h400);
    cmp("far_fault0", {31'b0, bus_if.fetch_fault_o}, 32'h0);
    cyc(1);
    cmp("far_fault", {31'b0, bus_if.fetch_fault_o}, 32'h1);
    cmp("far_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    cyc(2);
    cmp("far_hold", bus_if.imem_addr_o, 32'h400);

    // Sequential fetch from 0 up to the end of memory
    redirect(32'h0);
    for (int i = 0; i < 100 && bus_if.imem_addr_o != 32'h100; i++) cyc(1);
    cmp("reach_end", bus_if.imem_addr_o, 32'h100);
    cmp("last_pc", bus_if.if_id_pc_o, 32'hFC);
    cyc(1);
    cmp("end_fault", {31'b0, bus_if.fetch_fault_o}, 32'h1);
    cmp("end_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    bus_if.stall_i = 1'b1;
    cyc(3);
    cmp("halt_addr", bus_if.imem_addr_o, 32'h100);
    cmp("halt_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    bus_if.stall_i = 1'b0;
    cyc(2);
    cmp("halt_fault", {31'b0, bus_if.fetch_fault_o}, 32'h0);

    // Resume from HALT
    redirect(32'h0);
    cyc(1);
    cmp("resume_instr", bus_if.if_id_instr_o, 32'h0000_0093);
    cmp("resume_valid", {31'b0, bus_if.if_id_valid_o}, 32'h1);
    cyc(4);

    // Mid-stream reset overriding stall and redirect
    rstn = 1'b0;
    bus_if.stall_i = 1'b1;
    bus_if.redirect_valid_i = 1'b1;
    bus_if.redirect_pc_i = 32'h40;
    cyc(1);
    bus_if.stall_i = 1'b0;
    bus_if.redirect_valid_i = 1'b0;
    cmp("mrst_addr", bus_if.imem_addr_o, 32'h0);
    cmp("mrst_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    cmp("mrst_instr", bus_if.if_id_instr_o, 32'h13);
    cmp("mrst_pc", bus_if.if_id_pc_o, 32'h0);
    cmp("mrst_pc4", bus_if.if_id_pc_plus4_o, 32'h0);
    cmp("mrst_fault", {31'b0, bus_if.fetch_fault_o}, 32'h0);
    rstn = 1'b1;
    cyc(1);
    cmp("mrst_c1_valid", {31'b0, bus_if.if_id_valid_o}, 32'h0);
    cyc(1);
    cmp("mrst_c2_valid", {31'b0, bus_if.if_id_valid_o}, 32'h1);
    cmp("mrst_c2_pc", bus_if.if_id_pc_o, 32'h0);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
